i2c_av_config_arbiter: RTL and testbench

Shares the single I2C byte-level serial controller between the power-up auto-initialisation sequencer and runtime register writes, such as audio volume or video tweaks, issued by the host logic. Until auto-init reports completion, the arbiter passes the sequencer straight through to the controller. Runtime commands arriving during that time are buffered. After completion, the arbiter owns the controller permanently. It drains buffered 3-byte writes (device address, register, data) with start and stop, and returns one response per command.

---
 rtl/i2c_av_pkg.sv | 22 ++
 rtl/i2c_av_cmd_fifo.sv | 47 ++++
 rtl/i2c_av_config_arbiter.sv | 144 ++++++++++++++
 tb/tb_i2c_av_config_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_av_pkg.sv
// rtl/i2c_av_pkg.sv - shared types and field positions for the I2C AV config arbiter
package i2c_av_pkg;

  typedef enum logic [2:0] {
    RUN_IDLE = 3'd0,
    RUN_B0   = 3'd1,
    RUN_B1   = 3'd2,
    RUN_B2   = 3'd3,
    RUN_STOP = 3'd4,
    RUN_RESP = 3'd5
  } run_state_t;

  typedef enum logic {
    GRANT_INIT = 1'b0,
    GRANT_RUN  = 1'b1
  } grant_t;

  localparam int DEV_HI = 23;
  localparam int REG_HI = 15;
  localparam int DAT_HI = 7;

endpackage

// File: rtl/i2c_av_cmd_fifo.sv
// rtl/i2c_av_cmd_fifo.sv - synchronous FIFO buffering 24-bit runtime write commands
module i2c_av_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [23:0]   wr_data,
  input  logic          pop,
  output logic [23:0]   rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [23:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Full refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/i2c_av_config_arbiter.sv
// rtl/i2c_av_config_arbiter.sv - shares the I2C controller between auto-init and runtime writes
module i2c_av_config_arbiter
  import i2c_av_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  init_data,
  input  logic        init_transfer_data,
  input  logic        init_send_start_bit,
  input  logic        init_send_stop_bit,
  input  logic        init_auto_init_complete,
  output logic        init_transfer_complete,
  output logic        init_ack,
  input  logic        cmd_valid,
  input  logic [23:0] cmd_data,
  output logic        cmd_ready,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [7:0]  i2c_data_out,
  output logic        i2c_transfer_data,
  output logic        i2c_send_start_bit,
  output logic        i2c_send_stop_bit,
  input  logic        i2c_transfer_complete,
  input  logic        i2c_ack,
  output logic        busy,
  output logic [7:0]  error_count
);

  grant_t             grant;
  run_state_t         state;
  logic [23:0]        cmd_reg;
  logic               err;
  logic               td_r;
  logic               start_r;
  logic               stop_r;
  logic [7:0]         data_r;
  logic [7:0]         cur_byte;
  logic [23:0]        fifo_rd;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_AW:0]   fifo_level;
  logic               fifo_pop;
  logic               run_grant;

  assign run_grant = (grant == GRANT_RUN);
  assign cmd_ready = !fifo_full;
  assign fifo_pop  = run_grant && (state == RUN_IDLE) && !fifo_empty;

  i2c_av_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_valid),
    .wr_data (cmd_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Hand-over waits until the sequencer is between transfers so no byte is cut.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant <= GRANT_INIT;
    end else if (!run_grant && init_auto_init_complete &&
                 !init_transfer_data && !init_send_stop_bit) begin
      grant <= GRANT_RUN;
    end
  end

  always_comb begin
    cur_byte = cmd_reg[DAT_HI -: 8];
    if (state == RUN_B0)      cur_byte = cmd_reg[DEV_HI -: 8];
    else if (state == RUN_B1) cur_byte = cmd_reg[REG_HI -: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN_IDLE;
      cmd_reg     <= '0;
      err         <= 1'b0;
      td_r        <= 1'b0;
      start_r     <= 1'b0;
      stop_r      <= 1'b0;
      data_r      <= '0;
      error_count <= '0;
    end else begin
      case (state)
        RUN_IDLE: begin
          if (fifo_pop) begin
            cmd_reg <= fifo_rd;
            err     <= 1'b0;
            state   <= RUN_B0;
          end
        end
        RUN_B0, RUN_B1, RUN_B2: begin
          if (td_r && i2c_transfer_complete) begin
            td_r    <= 1'b0;
            start_r <= 1'b0;
            err     <= err | i2c_ack;
            if (i2c_ack || state == RUN_B2) state <= RUN_STOP;
            else state <= (state == RUN_B0) ? RUN_B1 : RUN_B2;
          end else if (!td_r && !i2c_transfer_complete) begin
            td_r    <= 1'b1;
            data_r  <= cur_byte;
            start_r <= (state == RUN_B0);
          end
        end
        RUN_STOP: begin
          if (stop_r && i2c_transfer_complete) begin
            stop_r <= 1'b0;
            state  <= RUN_RESP;
          end else if (!stop_r && !i2c_transfer_complete) begin
            stop_r <= 1'b1;
          end
        end
        RUN_RESP: begin
          if (err && error_count != 8'hFF) error_count <= error_count + 8'd1;
          state <= RUN_IDLE;
        end
        default: state <= RUN_IDLE;
      endcase
    end
  end

  assign resp_valid = (state == RUN_RESP);
  assign resp_error = (state == RUN_RESP) && err;
  assign busy       = !run_grant || (state != RUN_IDLE) || (fifo_level != '0);

  assign i2c_data_out       = run_grant ? data_r  : init_data;
  assign i2c_transfer_data  = run_grant ? td_r    : init_transfer_data;
  assign i2c_send_start_bit = run_grant ? start_r : init_send_start_bit;
  assign i2c_send_stop_bit  = run_grant ? stop_r  : init_send_stop_bit;

  assign init_transfer_complete = run_grant ? 1'b0 : i2c_transfer_complete;
  assign init_ack               = run_grant ? 1'b0 : i2c_ack;

endmodule

// File: tb/tb_i2c_av_config_arbiter.sv
// tb/tb_i2c_av_config_arbiter.sv - scoreboard bench with a behavioural I2C controller responder
module tb_i2c_av_config_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  init_data;
  logic        init_transfer_data, init_send_start_bit, init_send_stop_bit;
  logic        init_auto_init_complete;
  logic        init_transfer_complete, init_ack;
  logic        cmd_valid;
  logic [23:0] cmd_data;
  logic        cmd_ready, resp_valid, resp_error;
  logic [7:0]  i2c_data_out;
  logic        i2c_transfer_data, i2c_send_start_bit, i2c_send_stop_bit;
  logic        i2c_transfer_complete, i2c_ack;
  logic        busy;
  logic [7:0]  error_count;

  always #5 clk = ~clk;

  i2c_av_config_arbiter dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .init_data               (init_data),
    .init_transfer_data      (init_transfer_data),
    .init_send_start_bit     (init_send_start_bit),
    .init_send_stop_bit      (init_send_stop_bit),
    .init_auto_init_complete (init_auto_init_complete),
    .init_transfer_complete  (init_transfer_complete),
    .init_ack                (init_ack),
    .cmd_valid               (cmd_valid),
    .cmd_data                (cmd_data),
    .cmd_ready               (cmd_ready),
    .resp_valid              (resp_valid),
    .resp_error              (resp_error),
    .i2c_data_out            (i2c_data_out),
    .i2c_transfer_data       (i2c_transfer_data),
    .i2c_send_start_bit      (i2c_send_start_bit),
    .i2c_send_stop_bit       (i2c_send_stop_bit),
    .i2c_transfer_complete   (i2c_transfer_complete),
    .i2c_ack                 (i2c_ack),
    .busy                    (busy),
    .error_count             (error_count)
  );

  int checks = 0;
  int errors = 0;

  // Per-command NACK position: 0..2 = byte index that is NACKed, 3 = all ACKed.
  int         plan_q[$];
  logic [9:0] exp_byte_q[$];   // {is_stop, start, byte}
  bit         exp_resp_q[$];
  int         exp_ec = 0;
  bit         ec_pending = 0;
  bit         run_mode = 0;
  bit         resp_en = 0;
  bit         stall = 0;
  bit         stall_nonstart = 0;

  int         r_dly = 0;
  int         r_nack = 3;
  int         r_idx = 0;
  logic [9:0] r_obs;
  logic [9:0] r_exp;
  logic       r_ack;
  bit         m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic expect_cmd(input logic [23:0] d, input int p);
    plan_q.push_back(p);
    exp_byte_q.push_back({2'b01, d[23:16]});
    if (p != 0) exp_byte_q.push_back({2'b00, d[15:8]});
    if (p > 1)  exp_byte_q.push_back({2'b00, d[7:0]});
    exp_byte_q.push_back(10'h200);
    exp_resp_q.push_back(p < 3);
  endtask

  task automatic push_cmd(input logic [23:0] d, input int p);
    int n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) fail_now("push_timeout");
    else begin
      expect_cmd(d, p);
      cmd_valid = 1'b1;
      cmd_data  = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    bit done = 0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_resp_q.size() == 0 && !ec_pending) done = 1;
    end
    if (!done) fail_now("drain_timeout");
  endtask

  // Behavioural controller: acknowledges each byte or stop after a short random delay.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (resp_en) begin
        if (i2c_transfer_complete) begin
          if (!i2c_transfer_data && !i2c_send_stop_bit) begin
            i2c_transfer_complete = 1'b0;
            i2c_ack = 1'b0;
          end
        end else if ((i2c_transfer_data || i2c_send_stop_bit) && !stall &&
                     !(stall_nonstart && i2c_transfer_data && !i2c_send_start_bit)) begin
          if (r_dly > 0) r_dly--;
          else begin
            r_dly = $urandom_range(0, 2);
            r_obs = i2c_send_stop_bit ? 10'h200 : {1'b0, i2c_send_start_bit, i2c_data_out};
            if (exp_byte_q.size() == 0) fail_now("unexpected_i2c_transfer");
            else begin
              r_exp = exp_byte_q.pop_front();
              check("i2c_byte", r_obs, r_exp);
            end
            r_ack = 1'b0;
            if (!i2c_send_stop_bit) begin
              if (i2c_send_start_bit) begin
                r_nack = (plan_q.size() != 0) ? plan_q.pop_front() : 3;
                r_idx = 0;
              end
              r_ack = (r_idx == r_nack);
              r_idx++;
            end
            i2c_ack = r_ack;
            i2c_transfer_complete = 1'b1;
            #1;
            if (run_mode) check("init_tc_masked", init_transfer_complete, 1'b0);
          end
        end
      end
    end
  end

  // Response monitor and error_count model.
  initial begin
    forever begin
      @(negedge clk);
      if (ec_pending) begin
        check("error_count", error_count, exp_ec);
        ec_pending = 0;
      end
      if (resp_valid) begin
        if (exp_resp_q.size() == 0) fail_now("unexpected_resp");
        else begin
          m_err = exp_resp_q.pop_front();
          check("resp_error", resp_error, m_err);
          if (m_err && exp_ec < 255) exp_ec++;
          ec_pending = 1;
        end
      end
    end
  end

  initial begin
    logic [23:0] d;
    int n;
    reset_n = 1'b0;
    init_data = '0;
    init_transfer_data = 1'b0;
    init_send_start_bit = 1'b0;
    init_send_stop_bit = 1'b0;
    init_auto_init_complete = 1'b0;
    cmd_valid = 1'b0;
    cmd_data = '0;
    i2c_transfer_complete = 1'b0;
    i2c_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_busy", busy, 1'b1);
    check("reset_resp_valid", resp_valid, 1'b0);
    check("reset_error_count", error_count, 8'h00);
    check("reset_i2c_td", i2c_transfer_data, 1'b0);

    // Passthrough under INIT
    init_transfer_data = 1'b1;
    init_data = 8'h34;
    init_send_start_bit = 1'b1;
    #1;
    check("pass_td", i2c_transfer_data, 1'b1);
    check("pass_data", i2c_data_out, 8'h34);
    check("pass_start", i2c_send_start_bit, 1'b1);
    i2c_transfer_complete = 1'b1;
    #1 check("pass_tc", init_transfer_complete, 1'b1);
    i2c_ack = 1'b1;
    #1 check("pass_ack", init_ack, 1'b1);
    init_transfer_data = 1'b0;
    init_send_start_bit = 1'b0;
    init_data = '0;
    i2c_transfer_complete = 1'b0;
    i2c_ack = 1'b0;
    @(posedge clk);

    // Buffer during init, then drain after completion
    resp_en = 1;
    push_cmd(24'h340C05, 3);
    repeat (5) @(negedge clk);
    check("buffered_no_i2c", i2c_transfer_data, 1'b0);
    check("buffered_busy", busy, 1'b1);
    @(posedge clk); #1;
    init_auto_init_complete = 1'b1;
    repeat (2) @(posedge clk);
    run_mode = 1;
    wait_idle(500);
    check("after_first_ec", error_count, 8'd0);

    // NACK on the device byte
    push_cmd(24'h341A7B, 0);
    wait_idle(500);
    check("nack_ec", error_count, 8'd1);

    // Randomised traffic
    for (int i = 0; i < 24; i++) begin
      d = 24'($urandom);
      push_cmd(d, $urandom_range(0, 3));
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    wait_idle(3000);

    // Back-pressure with a stalled controller; first command also checks latency
    stall = 1;
    push_cmd(24'hA1B2C3, $urandom_range(0, 3));
    check("lat_e0_td", i2c_transfer_data, 1'b0);
    @(posedge clk); #1;
    check("lat_e1_td", i2c_transfer_data, 1'b0);
    @(posedge clk); #1;
    check("lat_e2_td", i2c_transfer_data, 1'b1);
    check("lat_e2_start", i2c_send_start_bit, 1'b1);
    check("lat_e2_data", i2c_data_out, 8'hA1);
    for (int i = 0; i < 4; i++) push_cmd(24'h100000 * (i + 2) + 24'h0102 * i, $urandom_range(0, 3));
    @(negedge clk);
    check("bp_full_ready", cmd_ready, 1'b0);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_data = 24'hDEAD01;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("bp_still_full", cmd_ready, 1'b0);
    stall = 0;
    wait_idle(2000);

    // Reset while the second byte is outstanding
    stall_nonstart = 1;
    push_cmd(24'h5A6B7C, 3);
    n = 0;
    while (!(i2c_transfer_data && !i2c_send_start_bit) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) fail_now("reach_b1_timeout");
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("rst_td", i2c_transfer_data, 1'b0);
    check("rst_start", i2c_send_start_bit, 1'b0);
    check("rst_stop", i2c_send_stop_bit, 1'b0);
    check("rst_data", i2c_data_out, 8'h00);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_error_count", error_count, 8'h00);
    plan_q.delete();
    exp_byte_q.delete();
    exp_resp_q.delete();
    exp_ec = 0;
    ec_pending = 0;
    i2c_transfer_complete = 1'b0;
    i2c_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    stall_nonstart = 0;
    repeat (4) @(negedge clk);
    check("post_rst_fifo_lost", busy, 1'b0);

    // Error counter saturation
    for (int i = 0; i < 256; i++) push_cmd(24'($urandom), 0);
    wait_idle(20000);
    check("sat_ec_255", error_count, 8'd255);
    push_cmd(24'h3456AB, 0);
    wait_idle(500);
    check("sat_ec_hold", error_count, 8'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
